// File: rtl/axis_data_fifo_if.sv
// AXI4-Stream bundle shared by the FIFO's upstream and downstream sides.
//   master modport : drives tvalid and the data fields, samples tready
//   slave modport  : samples tvalid and the data fields, drives tready
// Fields: tvalid, tready, tdata (TDATA_WIDTH*8), tstrb/tkeep (TDATA_WIDTH),
//         tlast, tid (TID_WIDTH), tdest (TDEST_WIDTH), tuser (TUSER_WIDTH)
interface axis_data_fifo_if #(
    parameter int TDATA_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
);
    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH*8-1:0] tdata;
    logic [TDATA_WIDTH-1:0]   tstrb;
    logic [TDATA_WIDTH-1:0]   tkeep;
    logic                     tlast;
    logic [TID_WIDTH-1:0]     tid;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_data_fifo.sv
// Synchronous first-word-fall-through AXI4-Stream FIFO with optional packet mode.
// Ports:
//   aclk, aresetn  : clock (rising edge), asynchronous active-low reset
//   s_axis         : upstream stream (slave side), s_axis.tready = not full
//   m_axis         : downstream stream (master side), head entry presented FWFT
//   data_count     : entries stored, 0..FIFO_DEPTH
//   pkt_count      : tlast beats currently stored
//   overflow       : registered 1-cycle pulse after a cycle with tvalid while full
// In packet mode the head is only released once a whole packet is stored, or
// when the FIFO is full with no complete packet (forced flush via draining).
module axis_data_fifo #(
    parameter int TDATA_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    axis_data_fifo_if.slave             s_axis,
    axis_data_fifo_if.master            m_axis,
    output logic [$clog2(FIFO_DEPTH):0] data_count,
    output logic [$clog2(FIFO_DEPTH):0] pkt_count,
    output logic                        overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = TDATA_WIDTH * 8;
    localparam int EW = DW + 2 * TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ready_en;
    logic          draining;
    logic          full;
    logic          wr;
    logic          rd;
    logic          wr_last;
    logic          rd_last;
    logic [EW-1:0] wr_entry;

    assign full    = (data_count == CW'(FIFO_DEPTH));
    assign wr      = s_axis.tvalid & s_axis.tready;
    assign rd      = m_axis.tvalid & m_axis.tready;
    assign wr_last = wr & s_axis.tlast;
    assign rd_last = rd & m_axis.tlast;

    // ready_en holds tready low until the first clock after reset release
    assign s_axis.tready = ready_en & ~full;

    assign wr_entry = {s_axis.tuser, s_axis.tdest, s_axis.tid, s_axis.tlast,
                       s_axis.tkeep, s_axis.tstrb, s_axis.tdata};

    assign {m_axis.tuser, m_axis.tdest, m_axis.tid, m_axis.tlast,
            m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = mem[rd_ptr];

    always_comb begin
        m_axis.tvalid = (data_count != '0);
        if (PACKET_MODE != 0) begin
            m_axis.tvalid = (data_count != '0) & ((pkt_count != '0) | full | draining);
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge aclk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            pkt_count  <= '0;
            draining   <= 1'b0;
            overflow   <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            overflow <= s_axis.tvalid & full;

            if (wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (wr && !rd) begin
                data_count <= data_count + CW'(1);
            end else if (!wr && rd) begin
                data_count <= data_count - CW'(1);
            end

            if (wr_last && !rd_last) begin
                pkt_count <= pkt_count + CW'(1);
            end else if (!wr_last && rd_last) begin
                pkt_count <= pkt_count - CW'(1);
            end

            // Release of the tlast beat ends a forced flush
            if (rd_last) begin
                draining <= 1'b0;
            end else if (full && pkt_count == '0) begin
                draining <= 1'b1;
            end
        end
    end
endmodule
